// File: rtl/pwm_nonoverlap_gen.sv
// pwm_nonoverlap_gen
//   Complementary high-side/low-side PWM generator with non-overlap dead time,
//   over-current blanking windows, a period-synchronous duty shadow register
//   and duty clamping so the low-side window never wraps past the period end.
//
// Optional feature macro: PWM_BRAKE_EN (adds the brake input; low-side braking
// with a dead-time hold-off on release). Default build leaves it out.
//
// Parameters
//   WIDTH      : counter/duty width, period = 2**WIDTH clocks
//   NONOVERLAP : dead time in clocks
//   BLANK      : over-current blanking window length in clocks
//
// Ports
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   en           : run enable (0 holds counter at 0 and drives both sides low)
//   duty         : requested high-side duty in counts
//   brake        : (PWM_BRAKE_EN only) low-side brake request
//   PWM1         : high-side drive, registered
//   PWM2         : low-side drive, registered
//   PWM_synch    : period-start strobe (counter == 0)
//   ovr_I_blank  : over-current blanking indicator
//   duty_clamped : active shadow duty was clamped
module pwm_nonoverlap_gen #(
  parameter int unsigned WIDTH      = 11,
  parameter int unsigned NONOVERLAP = 64,
  parameter int unsigned BLANK      = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] duty,
`ifdef PWM_BRAKE_EN
  input  logic             brake,
`endif
  output logic             PWM1,
  output logic             PWM2,
  output logic             PWM_synch,
  output logic             ovr_I_blank,
  output logic             duty_clamped
);

  localparam int unsigned      MAX_I   = (1 << WIDTH) - 1;
  localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_I);
  localparam logic [WIDTH:0]   NO_X    = (WIDTH+1)'(NONOVERLAP);
  localparam logic [WIDTH:0]   BLANK_X = (WIDTH+1)'(BLANK);
  localparam logic [WIDTH:0]   LIM_X   = MAX_X - NO_X;
  localparam logic [WIDTH:0]   A_END   = NO_X + BLANK_X;
  localparam logic [WIDTH-1:0] LIM     = LIM_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  if (WIDTH < 4) begin : g_chk_width
    $error("pwm_nonoverlap_gen: WIDTH must be >= 4");
  end
  if (NONOVERLAP + BLANK > MAX_I) begin : g_chk_blank
    $error("pwm_nonoverlap_gen: NONOVERLAP+BLANK must not exceed 2**WIDTH-1");
  end
  if (2 * NONOVERLAP >= MAX_I) begin : g_chk_dead
    $error("pwm_nonoverlap_gen: 2*NONOVERLAP must be below 2**WIDTH-1");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             clamped_q, clamped_d;
  logic             pwm1_q, pwm1_d;
  logic             pwm2_q, pwm2_d;
  logic             first_q, first_d;
  logic             load;
  logic             duty_over;
  logic             win_a, win_b;
  logic             blank_c;
  logic [WIDTH:0]   cnt_x, shadow_x, lo_start;
`ifdef PWM_BRAKE_EN
  localparam logic [WIDTH-1:0] HOLD_INIT = WIDTH'(NONOVERLAP);
  logic [WIDTH-1:0] hold_q, hold_d;
`endif

  always_comb begin
    cnt_x    = {1'b0, cnt_q};
    shadow_x = {1'b0, shadow_q};
    lo_start = shadow_x + NO_X;

    cnt_d = en ? cnt_q + CNT_ONE : '0;

    // first_q makes the first clock after reset sample duty, so the first
    // period after release already runs with the requested duty.
    load      = !en || (cnt_q == CNT_MAX) || first_q;
    first_d   = 1'b0;
    duty_over = ({1'b0, duty} > LIM_X);
    shadow_d  = shadow_q;
    clamped_d = clamped_q;
    if (load) begin
      shadow_d  = duty_over ? LIM : duty;
      clamped_d = duty_over;
    end

    pwm1_d = en && (cnt_x >= NO_X) && (cnt_x < shadow_x);
    pwm2_d = en && (cnt_x >= lo_start) && (cnt_q != CNT_MAX);

    // All window bounds are WIDTH+1 bits wide, so window B simply ends at
    // MAX instead of wrapping into the next period.
    win_a   = (cnt_x > NO_X) && (cnt_x < A_END);
    win_b   = (cnt_x > lo_start) && (cnt_x < lo_start + BLANK_X);
    blank_c = en && (win_a || win_b);

`ifdef PWM_BRAKE_EN
    hold_d = hold_q;
    if (brake) begin
      pwm1_d  = 1'b0;
      pwm2_d  = en;
      blank_c = 1'b0;
      hold_d  = HOLD_INIT;
    end else if (hold_q != '0) begin
      // dead time after brake release before normal PWM resumes
      pwm1_d = 1'b0;
      pwm2_d = 1'b0;
      hold_d = hold_q - CNT_ONE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      shadow_q  <= '0;
      clamped_q <= 1'b0;
      pwm1_q    <= 1'b0;
      pwm2_q    <= 1'b0;
      first_q   <= 1'b1;
`ifdef PWM_BRAKE_EN
      hold_q    <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      clamped_q <= clamped_d;
      pwm1_q    <= pwm1_d;
      pwm2_q    <= pwm2_d;
      first_q   <= first_d;
`ifdef PWM_BRAKE_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign PWM1         = pwm1_q;
  assign PWM2         = pwm2_q;
  assign PWM_synch    = (cnt_q == '0);
  assign ovr_I_blank  = blank_c;
  assign duty_clamped = clamped_q;

endmodule

// File: tb/tb_pwm_nonoverlap_gen.sv
// Testbench for pwm_nonoverlap_gen (default build, WIDTH=11, NONOVERLAP=64,
// BLANK=128). A period-position model predicts every output each cycle;
// directed per-period measurements are checked against hand-computed values.
module tb_pwm_nonoverlap_gen;

  localparam int W    = 11;
  localparam int NO   = 64;
  localparam int BL   = 128;
  localparam int MAXV = 2047;
  localparam int LIM  = MAXV - NO;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [W-1:0]  duty = '0;
  logic          PWM1, PWM2, PWM_synch, ovr_I_blank, duty_clamped;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pwm_nonoverlap_gen #(.WIDTH(W), .NONOVERLAP(NO), .BLANK(BL)) dut (
    .clk(clk), .rst(rst), .en(en), .duty(duty),
    .PWM1(PWM1), .PWM2(PWM2), .PWM_synch(PWM_synch),
    .ovr_I_blank(ovr_I_blank), .duty_clamped(duty_clamped)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: position in period + active duty ----------------
  function automatic bit hi_win(input int p, input int d);
    return (p >= NO) && (p < d);
  endfunction
  function automatic bit lo_win(input int p, input int d);
    return (p >= d + NO) && (p != MAXV);
  endfunction
  function automatic bit blank_win(input int p, input int d);
    return ((p > NO) && (p < NO + BL)) || ((p > d + NO) && (p < d + NO + BL));
  endfunction

  int m_pos   = 0;
  int m_duty  = 0;
  bit m_clamp = 1'b0;
  bit m_p1    = 1'b0;
  bit m_p2    = 1'b0;
  bit m_first = 1'b1;
  bit cmp_on  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos <= 0; m_duty <= 0; m_clamp <= 1'b0;
      m_p1 <= 1'b0; m_p2 <= 1'b0; m_first <= 1'b1;
    end else begin
      m_p1    <= en && hi_win(m_pos, m_duty);
      m_p2    <= en && lo_win(m_pos, m_duty);
      m_pos   <= en ? (m_pos + 1) % (MAXV + 1) : 0;
      m_first <= 1'b0;
      if (!en || m_pos == MAXV || m_first) begin
        m_duty  <= (int'(duty) > LIM) ? LIM : int'(duty);
        m_clamp <= (int'(duty) > LIM);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("pwm1",    int'(PWM1),         int'(m_p1));
      chk("pwm2",    int'(PWM2),         int'(m_p2));
      chk("synch",   int'(PWM_synch),    int'(m_pos == 0));
      chk("blank",   int'(ovr_I_blank),  int'(en && blank_win(m_pos, m_duty)));
      chk("clamped", int'(duty_clamped), int'(m_clamp));
      chk("overlap", int'(PWM1 && PWM2), 0);
    end
  end

  // ---------------- one-period measurement aligned to PWM_synch ----------------
  typedef struct {
    int p1_first, p1_last, p1_len;
    int p2_first, p2_len;
    int bl_first, bl_len;
    int sy_len, clamp_mid;
  } meas_t;

  task automatic measure(input int chg_at, input int chg_duty, output meas_t r);
    int guard = 0;
    r = '{p1_first: -1, p1_last: -1, p1_len: 0, p2_first: -1, p2_len: 0,
          bl_first: -1, bl_len: 0, sy_len: 0, clamp_mid: -1};
    @(negedge clk);
    while (PWM_synch !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      chk("synch_timeout", guard, 0);
      return;
    end
    for (int i = 0; i <= MAXV; i++) begin
      if (i > 0) @(negedge clk);
      if (PWM1) begin
        if (r.p1_first < 0) r.p1_first = i;
        r.p1_last = i;
        r.p1_len++;
      end
      if (PWM2) begin
        if (r.p2_first < 0) r.p2_first = i;
        r.p2_len++;
      end
      if (ovr_I_blank) begin
        if (r.bl_first < 0) r.bl_first = i;
        r.bl_len++;
      end
      if (PWM_synch) r.sy_len++;
      if (i == 10) r.clamp_mid = int'(duty_clamped);
      if (i == chg_at) duty = W'(chg_duty);
    end
  endtask

  meas_t r;

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_pwm1",    int'(PWM1), 0);
    chk("rst_pwm2",    int'(PWM2), 0);
    chk("rst_synch",   int'(PWM_synch), 1);
    chk("rst_clamped", int'(duty_clamped), 0);
    chk("rst_blank",   int'(ovr_I_blank), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    cmp_on = 1'b1;

    // nominal duty 1024
    duty = 11'd1024;
    @(posedge clk);
    #2 en = 1'b1;
    measure(-1, 0, r);
    chk("nom_p1_first", r.p1_first, 65);
    chk("nom_p1_len",   r.p1_len,   960);
    chk("nom_p1_last",  r.p1_last,  1024);
    chk("nom_p2_first", r.p2_first, 1089);
    chk("nom_p2_len",   r.p2_len,   959);
    chk("nom_bl_first", r.bl_first, 65);
    chk("nom_bl_len",   r.bl_len,   254);
    chk("nom_sy_len",   r.sy_len,   1);
    chk("nom_clamp",    r.clamp_mid, 0);

    // clamp: 2047 -> 1983
    duty = 11'd2047;
    measure(-1, 0, r);
    chk("clp_p1_len",  r.p1_len,  1919);
    chk("clp_p1_last", r.p1_last, 1983);
    chk("clp_p2_len",  r.p2_len,  0);
    chk("clp_bl_len",  r.bl_len,  127);
    chk("clp_clamp",   r.clamp_mid, 1);
    chk("clp_model_shadow", m_duty, 1983);

    // mid-period change 512 -> 1536 at cnt=100
    duty = 11'd512;
    measure(100, 1536, r);
    chk("mid_p1_last",  r.p1_last,  512);
    chk("mid_p1_len",   r.p1_len,   448);
    chk("mid_p2_first", r.p2_first, 577);
    chk("mid_p2_len",   r.p2_len,   1471);
    chk("mid_clamp",    r.clamp_mid, 0);
    measure(-1, 0, r);
    chk("nxt_p1_last", r.p1_last, 1536);
    chk("nxt_p1_len",  r.p1_len,  1472);
    chk("nxt_p2_len",  r.p2_len,  447);

    // degenerate duty == NONOVERLAP: no high side at all
    duty = 11'd64;
    measure(-1, 0, r);
    chk("deg_p1_len",   r.p1_len,   0);
    chk("deg_p2_first", r.p2_first, 129);
    chk("deg_p2_len",   r.p2_len,   1919);
    chk("deg_bl_first", r.bl_first, 65);
    chk("deg_bl_len",   r.bl_len,   191);

    // disable for 10 clocks mid-period
    duty = 11'd1024;
    repeat (300) @(posedge clk);
    #2;
    chk("pre_dis_pwm1", int'(PWM1), 1);
    en = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("dis_pwm1",  int'(PWM1), 0);
      chk("dis_pwm2",  int'(PWM2), 0);
      chk("dis_synch", int'(PWM_synch), 1);
    end
    @(posedge clk);
    #2 en = 1'b1;

    // async reset pulse mid-period
    repeat (400) @(posedge clk);
    #2;
    chk("pre_rst_pwm1", int'(PWM1), 1);
    rst = 1'b1;
    #1;
    chk("arst_pwm1",  int'(PWM1), 0);
    chk("arst_pwm2",  int'(PWM2), 0);
    chk("arst_synch", int'(PWM_synch), 1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    measure(-1, 0, r);
    chk("rel_p1_first", r.p1_first, 65);
    chk("rel_p1_len",   r.p1_len,   960);
    chk("rel_p2_first", r.p2_first, 1089);
    chk("rel_sy_len",   r.sy_len,   1);

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
